// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the single-port data memory, with bounded
// locked bursts and registered per-port read data.
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  state_t             state;
  logic               prio;
  logic [CNT_W-1:0]   burst_cnt;

  logic               gnt_any;
  logic               gnt_port;
  logic               gnt_lock;
  logic               own_req;
  logic               own_lock;
  logic [CNT_W-1:0]   cnt_next;

  // Only the word-address bits reach memory; the rest are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:ADDR_W], m1_addr[31:ADDR_W]};

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      case (state)
        ARB: begin
          if (m0_req && m1_req) begin
            m0_gnt = ~prio;
            m1_gnt = prio;
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
        end
        LOCK0:   m0_gnt = m0_req;
        LOCK1:   m1_gnt = m1_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_we    = m0_we;
      mem_addr  = {{(32-ADDR_W){1'b0}}, m0_addr[ADDR_W-1:0]};
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = {{(32-ADDR_W){1'b0}}, m1_addr[ADDR_W-1:0]};
      mem_wdata = m1_wdata;
    end
  end

  assign gnt_any  = m0_gnt | m1_gnt;
  assign gnt_port = m1_gnt;
  assign gnt_lock = m1_gnt ? m1_lock : m0_lock;
  assign own_req  = (state == LOCK1) ? m1_req  : m0_req;
  assign own_lock = (state == LOCK1) ? m1_lock : m0_lock;
  assign cnt_next = burst_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARB;
      prio      <= 1'b0;
      burst_cnt <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt && !m0_we) m0_rdata <= mem_rdata;
      if (m1_gnt && !m1_we) m1_rdata <= mem_rdata;
      if (gnt_any) prio <= ~gnt_port;

      case (state)
        ARB: begin
          // A single-beat burst limit means a lock can never outlive its first grant.
          if (gnt_any && gnt_lock && (MAX_BURST > 1)) begin
            state     <= gnt_port ? LOCK1 : LOCK0;
            burst_cnt <= CNT_W'(1);
          end
        end
        LOCK0, LOCK1: begin
          if (gnt_any) begin
            if (!gnt_lock || (cnt_next == CNT_W'(MAX_BURST))) begin
              state     <= ARB;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= cnt_next;
            end
          end else if (!own_req && !own_lock) begin
            state     <= ARB;
            burst_cnt <= '0;
          end
        end
        default: begin
          state     <= ARB;
          burst_cnt <= '0;
        end
      endcase
    end
  end

endmodule
